// File: rtl/fetch_sequencer_if.sv
// Bundle of handshake and bus signals between the fetch sequencer and its
// neighbours: hazard unit, decode-stage branch/jump logic, fetch datapath and
// instruction memory.
// Optional feature macro: FETCH_PERF_EN (adds the performance counter signals).
interface fetch_sequencer_if
`ifdef FETCH_PERF_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ();

  logic        stallF;
  logic        pcsrcD;
  logic [31:0] pcbranchD;
  logic        jumpD;
  logic [31:0] jumptargetD;
  logic        imem_ready;
  logic [31:0] pcF;
  logic        imem_req;
  logic        lowEn;
  logic        clr;
  logic [1:0]  fsm_state;
`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;
`endif

`ifdef FETCH_PERF_EN
  // Sequencer side.
  modport master (
    input  stallF, pcsrcD, pcbranchD, jumpD, jumptargetD, imem_ready,
    output pcF, imem_req, lowEn, clr, fsm_state, stall_cnt, redirect_cnt
  );
  // Environment side (hazard unit, decode, memory).
  modport slave (
    output stallF, pcsrcD, pcbranchD, jumpD, jumptargetD, imem_ready,
    input  pcF, imem_req, lowEn, clr, fsm_state, stall_cnt, redirect_cnt
  );
`else
  // Sequencer side.
  modport master (
    input  stallF, pcsrcD, pcbranchD, jumpD, jumptargetD, imem_ready,
    output pcF, imem_req, lowEn, clr, fsm_state
  );
  // Environment side (hazard unit, decode, memory).
  modport slave (
    output stallF, pcsrcD, pcbranchD, jumpD, jumptargetD, imem_ready,
    input  pcF, imem_req, lowEn, clr, fsm_state
  );
`endif

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC and chooses each cycle between
// redirect, hazard hold, sequential advance and waiting on instruction memory.
// Optional feature macro: FETCH_PERF_EN (saturating stall/redirect counters).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_PERF_EN
  , parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // The PC is always word aligned, including straight out of reset.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        stall_event;

  // Next state, next PC and the Mealy pipeline controls.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so
    // no path leaves a variable unassigned and no latch is inferred.
    state_d         = state_q;
    pc_d            = pc_q;
    bus.imem_req    = 1'b0;
    bus.lowEn       = 1'b0;
    bus.clr         = 1'b0;
    redirect        = 1'b0;
    stall_event     = 1'b0;
    // jumpD outranks pcsrcD when decode reports both.
    redirect_target = (bus.jumpD ? bus.jumptargetD : bus.pcbranchD) & 32'hFFFF_FFFC;

    case (state_q)
      IDLE: begin
        bus.clr = 1'b1;
        state_d = FETCH;
      end
      FETCH, WAIT: begin
        bus.imem_req = 1'b1;
        if (bus.jumpD || bus.pcsrcD) begin
          // Squash whatever was fetched this cycle, including a pending access.
          redirect = 1'b1;
          pc_d     = redirect_target;
          bus.clr  = 1'b1;
          state_d  = FETCH;
        end else if (bus.stallF) begin
          bus.lowEn   = 1'b1;
          stall_event = 1'b1;
        end else if (bus.imem_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end else begin
          bus.clr     = 1'b1;
          stall_event = 1'b1;
          state_d     = WAIT;
        end
      end
      default: begin
        bus.clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pcF       = pc_q;
  assign bus.fsm_state = state_q;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  // Saturating increments of the performance counters.
  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_event && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (redirect_cnt_q != '1)) begin
      redirect_cnt_d = redirect_cnt_q + 1'b1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;
`else
  // Without counters the event flags have no consumer.
  logic unused_events;
  assign unused_events = stall_event ^ redirect;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, reset
// corner cases, then randomized stimulus against a behavioural model.
// Optional feature macro: FETCH_PERF_EN (also checks the counters).
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
`ifdef FETCH_PERF_EN
  localparam int unsigned CNT_W = 16;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;

`ifdef FETCH_PERF_EN
  fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();
  fetch_sequencer #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`else
  fetch_sequencer_if bus ();
  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] pb;
    logic        jump;
    logic [31:0] jt;
    logic        ready;
    logic        e_req;
    logic        e_low;
    logic        e_clr;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl [21];

  // Behavioural model state: plain numbers and flags, not the DUT encoding.
  longint m_pc;
  bit     m_idle;
  bit     m_waiting;
  longint m_stall;
  longint m_redir;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the Mealy outputs, then the registered
  // results after the edge.
  task automatic step(input string nm, input logic s, input logic p, input logic [31:0] pb,
                      input logic j, input logic [31:0] jt, input logic r,
                      input logic e_req, input logic e_low, input logic e_clr,
                      input logic [31:0] e_pc, input logic [1:0] e_st);
    @(negedge clk);
    bus.stallF      = s;
    bus.pcsrcD      = p;
    bus.pcbranchD   = pb;
    bus.jumpD       = j;
    bus.jumptargetD = jt;
    bus.imem_ready  = r;
    #1;
    check({nm, ".imem_req"}, 32'(bus.imem_req), 32'(e_req));
    check({nm, ".lowEn"}, 32'(bus.lowEn), 32'(e_low));
    check({nm, ".clr"}, 32'(bus.clr), 32'(e_clr));
    @(posedge clk);
    #1;
    check({nm, ".pcF"}, bus.pcF, e_pc);
    check({nm, ".fsm_state"}, 32'(bus.fsm_state), 32'(e_st));
  endtask

  // Reference rules: returns this cycle's controls and the post-edge PC/state.
  task automatic model_step(input logic s, input logic p, input logic [31:0] pb,
                            input logic j, input logic [31:0] jt, input logic r,
                            output logic e_req, output logic e_low, output logic e_clr,
                            output logic [31:0] e_pc, output logic [1:0] e_st);
    longint tgt;
    e_req = 1'b0;
    e_low = 1'b0;
    e_clr = 1'b0;
    if (m_idle) begin
      e_clr     = 1'b1;
      m_idle    = 1'b0;
      m_waiting = 1'b0;
    end else begin
      e_req = 1'b1;
      if (j || p) begin
        tgt       = j ? longint'(jt) : longint'(pb);
        m_pc      = tgt - (tgt % 4);
        e_clr     = 1'b1;
        m_waiting = 1'b0;
`ifdef FETCH_PERF_EN
        if (m_redir < CNT_MAX) m_redir++;
`endif
      end else if (s) begin
        e_low = 1'b1;
`ifdef FETCH_PERF_EN
        if (m_stall < CNT_MAX) m_stall++;
`endif
      end else if (r) begin
        m_pc      = (m_pc + 4) % 64'h1_0000_0000;
        m_waiting = 1'b0;
      end else begin
        e_clr     = 1'b1;
        m_waiting = 1'b1;
`ifdef FETCH_PERF_EN
        if (m_stall < CNT_MAX) m_stall++;
`endif
      end
    end
    e_pc = m_pc[31:0];
    e_st = m_idle ? 2'd0 : (m_waiting ? 2'd2 : 2'd1);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, ".pcF"}, bus.pcF, RST_PC);
    check({nm, ".fsm_state"}, 32'(bus.fsm_state), 32'd0);
    check({nm, ".imem_req"}, 32'(bus.imem_req), 32'd0);
    check({nm, ".lowEn"}, 32'(bus.lowEn), 32'd0);
    check({nm, ".clr"}, 32'(bus.clr), 32'd1);
`ifdef FETCH_PERF_EN
    check({nm, ".stall_cnt"}, 32'(bus.stall_cnt), 32'd0);
    check({nm, ".redirect_cnt"}, 32'(bus.redirect_cnt), 32'd0);
`endif
  endtask

  initial begin
    logic        s, p, j, r;
    logic [31:0] pb, jt;
    logic        e_req, e_low, e_clr;
    logic [31:0] e_pc;
    logic [1:0]  e_st;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.stallF      = 1'b0;
    bus.pcsrcD      = 1'b0;
    bus.pcbranchD   = 32'h0;
    bus.jumpD       = 1'b0;
    bus.jumptargetD = 32'h0;
    bus.imem_ready  = 1'b1;

    //             stall pcsrc pb            jump jt            rdy  req low clr pc            st
    tbl[0]  = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0104, 2'd1};
    tbl[1]  = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0108, 2'd1};
    tbl[2]  = '{N, Y, 32'h0000_2003, N, 32'h0,         Y, Y, N, Y, 32'h0000_2000, 2'd1};
    tbl[3]  = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_2004, 2'd1};
    tbl[4]  = '{N, Y, 32'h0000_0080, Y, 32'h0000_0040, Y, Y, N, Y, 32'h0000_0040, 2'd1};
    tbl[5]  = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0044, 2'd1};
    tbl[6]  = '{N, N, 32'h0,         Y, 32'h0000_0020, Y, Y, N, Y, 32'h0000_0020, 2'd1};
    tbl[7]  = '{Y, N, 32'h0,         N, 32'h0,         Y, Y, Y, N, 32'h0000_0020, 2'd1};
    tbl[8]  = '{Y, N, 32'h0,         N, 32'h0,         Y, Y, Y, N, 32'h0000_0020, 2'd1};
    tbl[9]  = '{Y, N, 32'h0,         N, 32'h0,         Y, Y, Y, N, 32'h0000_0020, 2'd1};
    tbl[10] = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0024, 2'd1};
    tbl[11] = '{N, N, 32'h0,         Y, 32'h0000_0030, Y, Y, N, Y, 32'h0000_0030, 2'd1};
    tbl[12] = '{N, N, 32'h0,         N, 32'h0,         N, Y, N, Y, 32'h0000_0030, 2'd2};
    tbl[13] = '{N, N, 32'h0,         Y, 32'h0000_0500, N, Y, N, Y, 32'h0000_0500, 2'd1};
    tbl[14] = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0504, 2'd1};
    tbl[15] = '{N, N, 32'h0,         Y, 32'hFFFF_FFFC, Y, Y, N, Y, 32'hFFFF_FFFC, 2'd1};
    tbl[16] = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0000, 2'd1};
    tbl[17] = '{Y, N, 32'h0,         N, 32'h0,         N, Y, Y, N, 32'h0000_0000, 2'd1};
    tbl[18] = '{N, N, 32'h0,         N, 32'h0,         N, Y, N, Y, 32'h0000_0000, 2'd2};
    tbl[19] = '{Y, N, 32'h0,         N, 32'h0,         N, Y, Y, N, 32'h0000_0000, 2'd2};
    tbl[20] = '{N, N, 32'h0,         N, 32'h0,         Y, Y, N, N, 32'h0000_0004, 2'd1};

    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    #1 check_reset_values("reset");
    release_reset();

    // One IDLE cycle with clr=1, then fetching starts at RESET_PC.
    step("idle", N, N, 32'h0, N, 32'h0, Y, N, N, Y, RST_PC, 2'd1);

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), tbl[i].stall, tbl[i].pcsrc, tbl[i].pb, tbl[i].jump,
           tbl[i].jt, tbl[i].ready, tbl[i].e_req, tbl[i].e_low, tbl[i].e_clr,
           tbl[i].e_pc, tbl[i].e_st);
`ifdef FETCH_PERF_EN
      if (i == 3) check("redirect_cnt_after_branch", 32'(bus.redirect_cnt), 32'd1);
      if (i == 4) check("redirect_cnt_after_dual", 32'(bus.redirect_cnt), 32'd2);
      if (i == 9) check("stall_cnt_after_hold", 32'(bus.stall_cnt), 32'd3);
      if (i == 20) begin
        check("stall_cnt_end", 32'(bus.stall_cnt), 32'd7);
        check("redirect_cnt_end", 32'(bus.redirect_cnt), 32'd6);
      end
`endif
    end

    // Enter WAIT, then assert reset mid-cycle: reset values must appear at once.
    step("to_wait", N, N, 32'h0, N, 32'h0, N, Y, N, Y, 32'h0000_0004, 2'd2);
    #3 reset = 1'b0;
    #1 check_reset_values("midreset");
    repeat (2) @(posedge clk);
    release_reset();
    step("rel_idle", N, N, 32'h0, N, 32'h0, Y, N, N, Y, RST_PC, 2'd1);
    step("rel_first", N, N, 32'h0, N, 32'h0, Y, Y, N, N, RST_PC + 32'd4, 2'd1);

    // Reset during a redirect cycle: asserted after the inputs are driven.
    @(negedge clk);
    bus.jumpD       = 1'b1;
    bus.jumptargetD = 32'h0000_0900;
    #1 reset = 1'b0;
    #1 check_reset_values("redir_reset");
    @(posedge clk);
    #1 check("redir_reset.held_pc", bus.pcF, RST_PC);
    bus.jumpD = 1'b0;

    // Randomized run against the behavioural model.
    release_reset();
    m_pc      = longint'(RST_PC);
    m_idle    = 1'b1;
    m_waiting = 1'b0;
    m_stall   = 0;
    m_redir   = 0;
    for (int k = 0; k < 400; k++) begin
      s  = ($urandom_range(3) == 0);
      p  = ($urandom_range(7) == 0);
      j  = ($urandom_range(7) == 0);
      r  = ($urandom_range(9) < 7);
      pb = $urandom;
      jt = $urandom;
      model_step(s, p, pb, j, jt, r, e_req, e_low, e_clr, e_pc, e_st);
      step("rand", s, p, pb, j, jt, r, e_req, e_low, e_clr, e_pc, e_st);
      check("rand.exclusive", 32'(bus.lowEn & bus.clr), 32'd0);
`ifdef FETCH_PERF_EN
      check("rand.stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
      check("rand.redirect_cnt", 32'(bus.redirect_cnt), 32'(m_redir));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
